// File: rtl/tick_pkg.sv
// tick_pkg: shared constants for the tick scheduler and its dividers.
//   CH_GAME / CH_DB  : config channel select values
//   PER_W            : width of programmable periods and counters
//   GAME_PER_DEF     : reset game period (about 60 Hz at 100 MHz)
//   DB_PER_DEF       : reset debounce period (10 ms at 100 MHz)
//   PER_MIN          : smallest legal programmed period
package tick_pkg;
   localparam logic CH_GAME      = 1'b0;
   localparam logic CH_DB        = 1'b1;
   localparam int   PER_W        = 24;
   localparam int   GAME_PER_DEF = 1666667;
   localparam int   DB_PER_DEF   = 1000000;
   localparam int   PER_MIN      = 2;
endpackage

// File: rtl/tick_div.sv
// tick_div: programmable divider producing a registered one-cycle strobe.
//   clk      in  : clock
//   rst      in  : synchronous active-high reset (counter 0, period DEF)
//   hold     in  : freeze the counter and block the wrap
//   load_req in  : a new period is waiting; taken on the next wrap edge
//   load_val in  : the new period
//   strobe   out : high the cycle after the counter reads period-1
//   wrap     out : this cycle is a wrap edge (counter at period-1, not held)
module tick_div #(
   parameter int           W   = 24,
   parameter logic [W-1:0] DEF = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         load_req,
   input  logic [W-1:0] load_val,
   output logic         strobe,
   output logic         wrap
);
   localparam logic [W-1:0] ONE = 1;
   logic [W-1:0] cnt_q, cnt_d, per_q, per_d;
   logic         strobe_q;
   always_comb begin
      wrap  = ~hold & (cnt_q == per_q - ONE);
      cnt_d = hold ? cnt_q : (wrap ? '0 : cnt_q + ONE);
      // a new period only takes effect at a wrap, where the counter restarts anyway
      per_d = (wrap & load_req) ? load_val : per_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         per_q    <= DEF;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         strobe_q <= wrap;
      end
   end
   assign strobe = strobe_q;
endmodule

// File: rtl/tick_sched.sv
// tick_sched: central timebase producing pixel, game and debounce clock enables.
//   clk_100mhz in  : board clock
//   rst        in  : synchronous active-high reset
//   pix_en     out : strobe every PIX_DIV cycles
//   game_tick  out : strobe every game period, suppressed while paused
//   db_tick    out : strobe every debounce period
//   pause      in  : level, freezes the game channel only
//   cfg_valid  in  : config request valid
//   cfg_ready  out : config shadow is free
//   cfg_sel    in  : 0 = game channel, 1 = debounce channel
//   cfg_period in  : requested period in cycles
//   cfg_err    out : one-cycle pulse, request rejected (period < 2)
//   frame_cnt  out : game tick count, present only with TICK_FRAME_CNT_EN
module tick_sched import tick_pkg::*; #(
   parameter int PIX_DIV      = 4,
   parameter int PER_W        = tick_pkg::PER_W,
   parameter int GAME_PER_DEF = tick_pkg::GAME_PER_DEF,
   parameter int DB_PER_DEF   = tick_pkg::DB_PER_DEF
) (
   input  logic             clk_100mhz,
   input  logic             rst,
   output logic             pix_en,
   output logic             game_tick,
   output logic             db_tick,
   input  logic             pause,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_sel,
   input  logic [PER_W-1:0] cfg_period,
   output logic             cfg_err
`ifdef TICK_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);
   logic             pend_q, pend_d, sel_q, sel_d, err_q, err_d, done_q, done_d;
   logic [PER_W-1:0] per_q, per_d;
   logic             xfer, bad, take, g_wrap, d_wrap, g_strobe, pix_wrap_unused;
   always_comb begin
      xfer   = cfg_valid & ~pend_q;
      bad    = cfg_period < PER_W'(PER_MIN);
      take   = xfer & ~bad;
      // done_q keeps the shadow busy for the cycle after the load
      done_d = pend_q & ~done_q & ((sel_q == CH_DB) ? d_wrap : g_wrap);
      pend_d = done_q ? 1'b0 : (pend_q | take);
      sel_d  = take ? cfg_sel : sel_q;
      per_d  = take ? cfg_period : per_q;
      err_d  = xfer & bad;
   end
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         pend_q <= 1'b0;
         sel_q  <= CH_GAME;
         per_q  <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         sel_q  <= sel_d;
         per_q  <= per_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end
   tick_div #(.W(PER_W), .DEF(PER_W'(PIX_DIV))) u_pix (
      .clk(clk_100mhz), .rst(rst), .hold(1'b0), .load_req(1'b0), .load_val('0),
      .strobe(pix_en), .wrap(pix_wrap_unused)
   );
   tick_div #(.W(PER_W), .DEF(PER_W'(GAME_PER_DEF))) u_game (
      .clk(clk_100mhz), .rst(rst), .hold(pause),
      .load_req(pend_q & ~done_q & (sel_q == CH_GAME)), .load_val(per_q),
      .strobe(g_strobe), .wrap(g_wrap)
   );
   tick_div #(.W(PER_W), .DEF(PER_W'(DB_PER_DEF))) u_db (
      .clk(clk_100mhz), .rst(rst), .hold(1'b0),
      .load_req(pend_q & ~done_q & (sel_q == CH_DB)), .load_val(per_q),
      .strobe(db_tick), .wrap(d_wrap)
   );
   // a strobe registered just before pause rises is dropped rather than leaking out
   assign game_tick = g_strobe & ~pause;
   assign cfg_ready = ~pend_q;
   assign cfg_err   = err_q;
`ifdef TICK_FRAME_CNT_EN
   logic [15:0] fc_q;
   always_ff @(posedge clk_100mhz) begin
      if (rst) fc_q <= '0;
      else if (game_tick) fc_q <= fc_q + 16'd1;
   end
   assign frame_cnt = fc_q;
`endif
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: scoreboard bench for tick_sched with short default periods.
module tb_tick_sched;
   localparam int PW = 24;
   logic clk_100mhz = 1'b0, rst = 1'b1, pause = 1'b0, cfg_valid = 1'b0, cfg_sel = 1'b0;
   logic [PW-1:0] cfg_period = '0;
   logic pix_en, game_tick, db_tick, cfg_ready, cfg_err;
   int   cyc = 0;
   logic rsts = 1'b1;
   int   total = 0, bad = 0;
   int   gq[$], dq[$], eq[$];
`ifdef TICK_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif
   tick_sched #(.PIX_DIV(4), .PER_W(PW), .GAME_PER_DEF(20), .DB_PER_DEF(12)) dut (
      .clk_100mhz(clk_100mhz), .rst(rst), .pix_en(pix_en), .game_tick(game_tick),
      .db_tick(db_tick), .pause(pause), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_period(cfg_period), .cfg_err(cfg_err)
`ifdef TICK_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );
   always #5 clk_100mhz = ~clk_100mhz;
   // cyc is 0 in the first cycle after reset releases
   always @(posedge clk_100mhz) begin
      cyc  <= rst ? 0 : cyc + 1;
      rsts <= rst;
   end
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask
   always @(negedge clk_100mhz) begin
      if (rsts) begin
         chk("rst_pix", pix_en, 0);
         chk("rst_game", game_tick, 0);
         chk("rst_db", db_tick, 0);
         chk("rst_err", cfg_err, 0);
         chk("rst_ready", cfg_ready, 1);
      end else begin
         chk("pix_en", pix_en, int'(cyc != 0 && cyc % 4 == 0));
         if (game_tick) chk("game_tick_cyc", cyc, gq.size() != 0 ? gq.pop_front() : -1);
         if (db_tick) chk("db_tick_cyc", cyc, dq.size() != 0 ? dq.pop_front() : -1);
         if (cfg_err) chk("cfg_err_cyc", cyc, eq.size() != 0 ? eq.pop_front() : -1);
      end
   end
   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk_100mhz);
         #1;
      end
   endtask
   task automatic do_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk_100mhz);
      #1;
      rst = 1'b0;
   endtask
   task automatic cfg_write(input logic s, input int p);
      cfg_valid  = 1'b1;
      cfg_sel    = s;
      cfg_period = PW'(p);
      if (p < 2) eq.push_back(cyc + 1);
      @(posedge clk_100mhz);
      #1;
      cfg_valid = 1'b0;
   endtask
   task automatic end_phase(input string nm);
      chk({nm, "_game_missed"}, gq.size(), 0);
      chk({nm, "_db_missed"}, dq.size(), 0);
      chk({nm, "_err_missed"}, eq.size(), 0);
      gq.delete();
      dq.delete();
      eq.delete();
   endtask
   initial begin
      // defaults after reset
      do_reset;
      chk("a_ready", cfg_ready, 1);
      gq = '{20, 40};
      dq = '{12, 24, 36};
      wait_cyc(45);
`ifdef TICK_FRAME_CNT_EN
      chk("a_frame_cnt", frame_cnt, 2);
`endif
      end_phase("a");
      // game period 10 written at cycle 5; a write while busy is ignored
      do_reset;
      gq = '{20, 30, 40};
      dq = '{12, 24, 36};
      wait_cyc(5);
      chk("b_ready5", cfg_ready, 1);
      cfg_write(1'b0, 10);
      chk("b_ready6", cfg_ready, 0);
      wait_cyc(10);
      cfg_write(1'b1, 3);
      wait_cyc(20);
      chk("b_ready20", cfg_ready, 0);
      wait_cyc(21);
      chk("b_ready21", cfg_ready, 1);
      wait_cyc(45);
      end_phase("b");
      // illegal periods rejected
      do_reset;
      gq = '{20, 40};
      dq = '{12, 24, 36};
      wait_cyc(3);
      cfg_write(1'b0, 1);
      chk("c_ready4", cfg_ready, 1);
      wait_cyc(7);
      cfg_write(1'b0, 0);
      chk("c_ready8", cfg_ready, 1);
      wait_cyc(10);
      cfg_write(1'b1, 1);
      chk("c_ready11", cfg_ready, 1);
      wait_cyc(45);
      end_phase("c");
      // game period 8, pause rises with counter at 7
      do_reset;
      gq = '{20, 28, 49, 57};
      dq = '{12, 24, 36, 48, 60};
      wait_cyc(2);
      cfg_write(1'b0, 8);
      wait_cyc(35);
      pause = 1'b1;
      wait_cyc(48);
      pause = 1'b0;
      wait_cyc(63);
`ifdef TICK_FRAME_CNT_EN
      chk("d_frame_cnt", frame_cnt, 4);
`endif
      end_phase("d");
      // pending debounce write dropped by reset
      do_reset;
      wait_cyc(3);
      cfg_write(1'b1, 5);
      chk("e_ready_pend", cfg_ready, 0);
      wait_cyc(6);
      do_reset;
      chk("e_ready_after", cfg_ready, 1);
      gq = '{20};
      dq = '{12, 24};
      wait_cyc(25);
      end_phase("e");
      // transfer on the debounce wrap cycle applies at the following wrap
      do_reset;
      gq = '{20, 40};
      dq = '{12, 24, 30, 36};
      wait_cyc(11);
      cfg_write(1'b1, 6);
      chk("f_ready12", cfg_ready, 0);
      wait_cyc(24);
      chk("f_ready24", cfg_ready, 0);
      wait_cyc(25);
      chk("f_ready25", cfg_ready, 1);
      wait_cyc(41);
      end_phase("f");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
